// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// requester IDs and default bus widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   localparam logic REQ_F = 1'b0;
   localparam logic REQ_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch (F) and data (D) requesters.
// Build option ARB_RR_EN: when defined, simultaneous requests are resolved
// round-robin using the previous winner; otherwise D has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic f_req,
`ifdef ARB_RR_EN
   input  logic last_winner,
`endif
   input  logic d_req,
   output logic winner,
   output logic valid
);

   // Pick a winner whenever at least one requester is asking.
   always_comb begin
      valid  = f_req | d_req;
      winner = REQ_F;
`ifdef ARB_RR_EN
      if (f_req && d_req) begin
         winner = ~last_winner;
      end else if (d_req) begin
         winner = REQ_D;
      end
`else
      if (d_req) begin
         winner = REQ_D;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory. One transaction
// takes three cycles: IDLE (grant and latch), ACCESS (memory strobe), DONE (ack).
// Build option ARB_RR_EN: round-robin arbitration with a last-winner register
// instead of fixed D-over-F priority.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches the winner's command
// ACCESS | drives the memory for one cycle, captures read data on the edge
// DONE   | one-cycle ack to the winner; requests are ignored
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_q, grant_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              pick_winner;
   logic              pick_valid;
   logic              in_access;
   logic              in_done;

`ifdef ARB_RR_EN
   logic              last_q, last_d;
`endif

   mem_arb_pick u_pick (
      .f_req       (f_req),
`ifdef ARB_RR_EN
      .last_winner (last_q),
`endif
      .d_req       (d_req),
      .winner      (pick_winner),
      .valid       (pick_valid)
   );

   // State, latched command and read-data holding registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         grant_q   <= REQ_F;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_RR_EN
         last_q    <= REQ_F;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         grant_q   <= grant_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   // Next-state logic: grant and latch in IDLE, capture read data in ACCESS.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      grant_d   = grant_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
      last_d    = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ACCESS;
               grant_d = pick_winner;
`ifdef ARB_RR_EN
               last_d  = pick_winner;
`endif
               if (pick_winner == REQ_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  // Fetch is always a read; no write data is carried.
                  addr_d  = f_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         ACCESS: begin
            if (!we_q) begin
               if (grant_q == REQ_D) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  f_rdata_d = mem_rdata;
               end
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory strobes exist only in ACCESS, so read and write can never overlap
   // and an async reset removes them immediately.
   assign in_access = (state_q == ACCESS);
   assign in_done   = (state_q == DONE);

   assign mem_addr  = in_access ? addr_q  : '0;
   assign mem_wdata = in_access ? wdata_q : '0;
   assign mem_read  = in_access & ~we_q;
   assign mem_write = in_access &  we_q;

   assign f_ack     = in_done & (grant_q == REQ_F);
   assign d_ack     = in_done & (grant_q == REQ_D);
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = grant_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 16x8 program/data memory between two requesters: instruction fetch (F) and data load/store (D).
- Latches one request, drives the memory's address/read/write/data_in for exactly one cycle, captures read data and returns a one-cycle ack.
- Sits between the CPU control unit and the memory module.
- Default arbitration is fixed priority, D over F.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request, held until f_ack.
- f_addr  in  ADDR_W  fetch address.
- f_ack  out  1  one-cycle pulse; f_rdata valid this cycle.
- f_rdata  out  DATA_W  fetched byte, holds until next F ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data, holds until next D read ack.
- mem_addr  out  ADDR_W  to memory address.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (combinational).
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  0 = F, 1 = D; owner of the current or last transaction.

Behaviour:
- Clock and reset are fixed: clk, rst_n; one clock; rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; latched address, data and we 0.
  - When ARB_RR_EN is defined, the last-winner register resets to F (0).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay.
  - Otherwise pick a winner, latch its addr/we/wdata and grant_id, then go to ACCESS.
  - F is always a read (we = 0).
- ACCESS (exactly one cycle):
  - mem_addr = latched address.
  - mem_read = !we; mem_write = we; mem_wdata = latched wdata.
  - On the clock edge, capture mem_rdata into the winner's rdata register only when it is a read.
  - Go to DONE.
- DONE:
  - Winner's ack = 1 for this cycle only; mem_read and mem_write = 0.
  - Go to IDLE unconditionally. Requests are not sampled in DONE.
- Latency: request seen in IDLE at cycle N → ACCESS at N+1 → ack at N+2.
  - Throughput is one access per 3 cycles.
  - A requester may keep req high after its ack to issue back-to-back transactions, with new addr valid by the next IDLE.
- mem_read and mem_write are never high together, and are never high outside ACCESS.
- The loser's rdata register and ack are untouched.
- Inputs changing while in ACCESS or DONE have no effect (the request is latched).
- Requester rule: req dropped before ack is a protocol violation. Behaviour is unspecified except that the latched transaction still completes.
- Reset mid-ACCESS: all outputs clear immediately, including mem_write. The transaction is aborted and no ack is issued.
- Address wrap: not applicable. Addresses are full ADDR_W and pass through unmodified.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. When both req are high in IDLE, the requester that did not win the previous grant wins. A 1-bit last-winner register updates on each grant. A single requester always wins.
- Undefined: fixed priority, D always beats F. There is no last-winner register, so F can starve under continuous d_req.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - requester ID constants REQ_F = 0, REQ_D = 1;
  - default ADDR_W and DATA_W.
- Sub-module mem_arb_pick:
  - inputs f_req, d_req, last_winner;
  - outputs winner and valid;
  - holds the `ifdef ARB_RR_EN` selection logic.
- The top-level mem_arbiter holds the FSM and latches.

Test Plan:
1. Reset with memory[12] = 0x0B; pulse f_req with f_addr = 12 → mem_read high for one cycle at N+1; f_ack at N+2; f_rdata = 0x0B; d_ack stays 0.
2. d_req with d_we = 1, d_addr = 13, d_wdata = 0xA5, then a D read of 13 → mem_write high for one cycle only; second d_ack gives d_rdata = 0xA5.
3. f_req and d_req both high continuously for 12 cycles.
   - Without ARB_RR_EN: 4 D acks, 0 F acks.
   - With ARB_RR_EN: acks alternate D, F, D, F; first winner D, since last-winner resets to F.
4. Assert rst_n low in the ACCESS cycle of a D write to address 3 → mem_write drops at once; no d_ack; memory[3] unchanged after release; FSM returns to IDLE.
5. Hold f_req high and change f_addr from 9 to 10 during ACCESS → f_rdata equals memory[9] (0x08); next transaction uses address 10 and returns 0x02.
6. Idle bench with no requests for 20 cycles → busy = 0; mem_read = mem_write = 0 throughout.
